// File: rtl/audio_pkg.sv
// ============================================================================
// Module : audio_pkg
// Brief  : Shared audio constants and helpers for the codec-side blocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package audio_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_SLOT_WIDTH = 32;

    // Bit-clock periods in one stereo frame (left slot + right slot).
    function automatic int frame_len(input int slot_width);
        return 2 * slot_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ============================================================================
// Module : sync_edge_detect
// Brief  : Registers a synchronous level; emits delayed level and edge strobes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic level_q,
    output logic rise,
    output logic fall
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
    assign fall = level_q & ~level;

endmodule

`default_nettype wire

// File: rtl/i2s_tx.sv
// ============================================================================
// Module : i2s_tx
// Brief  : Philips I2S serialiser with a one-deep stereo sample buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2s_tx
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SLOT_WIDTH = DEFAULT_SLOT_WIDTH
) (
    input  logic                  in_clk,
    input  logic                  rst_n,
    input  logic                  bclk,
    input  logic [DATA_WIDTH-1:0] left_data,
    input  logic [DATA_WIDTH-1:0] right_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  bclk_out,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  underrun
);

    localparam int FRAME_LEN = frame_len(SLOT_WIDTH);
    localparam int POS_W     = $clog2(FRAME_LEN);

    localparam logic [POS_W-1:0] C_POS_LAST    = POS_W'(FRAME_LEN - 1);
    localparam logic [POS_W-1:0] C_SLOT_START  = POS_W'(SLOT_WIDTH);
    localparam logic [POS_W-1:0] C_LEFT_FIRST  = POS_W'(1);
    localparam logic [POS_W-1:0] C_LEFT_LAST   = POS_W'(DATA_WIDTH);
    localparam logic [POS_W-1:0] C_RIGHT_FIRST = POS_W'(SLOT_WIDTH + 1);
    localparam logic [POS_W-1:0] C_RIGHT_LAST  = POS_W'(SLOT_WIDTH + DATA_WIDTH);

    logic                  w_bclk_q;
    logic                  w_fall;
    logic                  w_rise_unused;
    logic [POS_W-1:0]      w_pos_next;
    logic                  w_frame_load;
    logic                  w_left_bit;
    logic                  w_right_bit;
    logic                  w_hs;

    logic [POS_W-1:0]      r_pos;
    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_pend_l;
    logic [DATA_WIDTH-1:0] r_pend_r;
    logic [DATA_WIDTH-1:0] r_sr_l;
    logic [DATA_WIDTH-1:0] r_sr_r;
    logic                  r_sdata;
    logic                  r_lrclk;
    logic                  r_underrun;

    sync_edge_detect u_bclk_edge (
        .clk     (in_clk),
        .rst_n   (rst_n),
        .level   (bclk),
        .level_q (w_bclk_q),
        .rise    (w_rise_unused),
        .fall    (w_fall)
    );

    assign w_pos_next   = (r_pos == C_POS_LAST) ? '0 : r_pos + 1'b1;
    assign w_frame_load = w_fall & (r_pos == C_POS_LAST);
    assign w_left_bit   = (w_pos_next >= C_LEFT_FIRST)  && (w_pos_next <= C_LEFT_LAST);
    assign w_right_bit  = (w_pos_next >= C_RIGHT_FIRST) && (w_pos_next <= C_RIGHT_LAST);
    assign w_hs         = sample_valid & ~r_full;

    // Outputs are registered against the position being entered, so they
    // change on the same in_clk edge where bclk_out falls.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos      <= C_POS_LAST;
            r_full     <= 1'b0;
            r_pend_l   <= '0;
            r_pend_r   <= '0;
            r_sr_l     <= '0;
            r_sr_r     <= '0;
            r_sdata    <= 1'b0;
            r_lrclk    <= 1'b1;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_hs) begin
                r_pend_l <= left_data;
                r_pend_r <= right_data;
                r_full   <= 1'b1;
            end
            if (w_fall) begin
                r_pos   <= w_pos_next;
                r_lrclk <= (w_pos_next >= C_SLOT_START);
                if (w_frame_load) begin
                    r_sdata <= 1'b0;
                    if (r_full) begin
                        r_sr_l <= r_pend_l;
                        r_sr_r <= r_pend_r;
                        r_full <= 1'b0;
                    end else begin
                        r_sr_l     <= '0;
                        r_sr_r     <= '0;
                        r_underrun <= 1'b1;
                    end
                end else if (w_left_bit) begin
                    r_sdata <= r_sr_l[DATA_WIDTH-1];
                    r_sr_l  <= {r_sr_l[DATA_WIDTH-2:0], 1'b0};
                end else if (w_right_bit) begin
                    r_sdata <= r_sr_r[DATA_WIDTH-1];
                    r_sr_r  <= {r_sr_r[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    r_sdata <= 1'b0;
                end
            end
        end
    end

    assign sample_ready = ~r_full;
    assign bclk_out     = w_bclk_q;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sdata;
    assign underrun     = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
// ============================================================================
// Module : tb_i2s_tx
// Brief  : Self-checking bench for i2s_tx using a sample scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_i2s_tx;

    localparam int DW = 16;
    localparam int SW = 32;
    localparam int FL = 2 * SW;

    logic          in_clk = 1'b0;
    logic          rst_n;
    logic          bclk;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          sample_valid;
    logic          sample_ready;
    logic          bclk_out;
    logic          lrclk;
    logic          sdata;
    logic          underrun;

    i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
        .in_clk       (in_clk),
        .rst_n        (rst_n),
        .bclk         (bclk),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk_out     (bclk_out),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    typedef struct {
        logic [DW-1:0] l_in;
        logic [DW-1:0] r_in;
        logic [DW-1:0] l_bits;
        logic [DW-1:0] r_bits;
    } vec_t;

    pair_t sbq[$];
    pair_t cur   = '0;
    pair_t pend  = '0;
    int    total = 0;
    int    bad   = 0;
    int    mp    = FL - 1;
    int    frames = 0;
    int    underruns = 0;
    bit    hs_flag = 1'b0;
    bit    bclk_run = 1'b0;
    logic  prev_bo = 1'b0;
    logic  prev_sd = 1'b0;
    logic  prev_lr = 1'b1;
    event  bclk_fall_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t p=%0d)", name, act, exp, $time, mp);
        end
    endtask

    // Divide-by-4 bit clock, changed on the falling in_clk edge.
    initial begin : gen_bclk
        int ph;
        ph   = 0;
        bclk = 1'b0;
        forever begin
            @(negedge in_clk);
            if (bclk_run) begin
                ph++;
                if (ph == 2) begin
                    ph   = 0;
                    bclk = ~bclk;
                    if (!bclk) ->bclk_fall_ev;
                end
            end
        end
    end

    // Reference model: tracks frame position, pops the scoreboard at each frame start.
    always @(posedge in_clk) begin : mon
        logic exp_un;
        logic exp_sd;
        #1;
        if (!rst_n) begin
            prev_bo = 1'b0;
            prev_sd = sdata;
            prev_lr = lrclk;
        end else begin
            exp_un = 1'b0;
            if (prev_bo && !bclk_out) begin
                mp = (mp == FL - 1) ? 0 : mp + 1;
                if (mp == 0) begin
                    frames++;
                    if (sbq.size() > 0) begin
                        cur = sbq.pop_front();
                    end else begin
                        cur    = '0;
                        exp_un = 1'b1;
                    end
                end
                exp_sd = 1'b0;
                if (mp >= 1 && mp <= DW)
                    exp_sd = cur.l[DW - mp];
                else if (mp >= SW + 1 && mp <= SW + DW)
                    exp_sd = cur.r[SW + DW - mp];
                check("lrclk", lrclk, (mp >= SW) ? 1 : 0);
                check("sdata", sdata, exp_sd);
            end else begin
                check("sdata_align", sdata, prev_sd);
                check("lrclk_align", lrclk, prev_lr);
            end
            if (underrun) underruns++;
            check("underrun", underrun, exp_un);
            if (hs_flag) begin
                sbq.push_back(pend);
                hs_flag = 1'b0;
            end
            check("sample_ready", sample_ready, (sbq.size() == 0) ? 1 : 0);
            prev_bo = bclk_out;
            prev_sd = sdata;
            prev_lr = lrclk;
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        do begin
            @(negedge in_clk);
            k++;
        end while ((sbq.size() != 0 || hs_flag) && k < 2000);
        if (k >= 2000) begin
            total++;
            bad++;
            $display("FAIL wait_ready: timeout waiting for empty buffer");
        end
    endtask

    task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r,
                         input logic [DW-1:0] el, input logic [DW-1:0] er, input bit hold);
        wait_ready();
        sample_valid = 1'b1;
        left_data    = l;
        right_data   = r;
        pend         = '{l: el, r: er};
        hs_flag      = 1'b1;
        if (!hold) begin
            @(negedge in_clk);
            sample_valid = 1'b0;
        end
    endtask

    task automatic wait_frames(input int n);
        int tgt;
        int k;
        tgt = frames + n;
        k   = 0;
        while (frames < tgt && k < n * 400) begin
            @(negedge in_clk);
            k++;
        end
        if (frames < tgt) begin
            total++;
            bad++;
            $display("FAIL wait_frames: got %0d frames expected %0d", frames, tgt);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sdata"},        sdata, 0);
        check({tag, "_lrclk"},        lrclk, 1);
        check({tag, "_bclk_out"},     bclk_out, 0);
        check({tag, "_sample_ready"}, sample_ready, 1);
        check({tag, "_underrun"},     underrun, 0);
    endtask

    initial begin : main
        vec_t vecs[5];
        int   u0;
        int   k;
        vecs[0] = '{16'h8001, 16'h7FFE, 16'b1000_0000_0000_0001, 16'b0111_1111_1111_1110};
        vecs[1] = '{16'hFFFF, 16'h0000, 16'b1111_1111_1111_1111, 16'b0000_0000_0000_0000};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'b0000_0000_0000_0000, 16'b1111_1111_1111_1111};
        vecs[3] = '{16'hA5A5, 16'h5A5A, 16'b1010_0101_1010_0101, 16'b0101_1010_0101_1010};
        vecs[4] = '{16'h1234, 16'hFEDC, 16'b0001_0010_0011_0100, 16'b1111_1110_1101_1100};

        rst_n        = 1'b0;
        sample_valid = 1'b0;
        left_data    = '0;
        right_data   = '0;
        repeat (3) @(negedge in_clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // First pair offered before the bit clock starts, then two silent frames.
        offer(vecs[0].l_in, vecs[0].r_in, vecs[0].l_bits, vecs[0].r_bits, 1'b0);
        bclk_run = 1'b1;
        wait_frames(3);
        check("underrun_count_idle", underruns, 2);

        for (int i = 1; i < 5; i++) begin
            offer(vecs[i].l_in, vecs[i].r_in, vecs[i].l_bits, vecs[i].r_bits, 1'b0);
            wait_frames(1);
        end
        wait_frames(2);

        // Continuous valid: one pair per frame.
        u0 = underruns;
        for (int i = 0; i < 4; i++) begin
            offer(16'h0F00 + 16'(i), 16'hC003 ^ 16'(i * 5),
                  16'h0F00 + 16'(i), 16'hC003 ^ 16'(i * 5), 1'b1);
        end
        @(negedge in_clk);
        sample_valid = 1'b0;
        wait_frames(1);
        check("underrun_count_stream", underruns, u0);
        wait_frames(2);

        // Handshake in the very cycle of a frame load with the buffer empty.
        k = 0;
        do begin
            @(bclk_fall_ev);
            k++;
        end while (!(mp == FL - 1 && sbq.size() == 0 && !hs_flag) && k < 200);
        u0 = underruns;
        sample_valid = 1'b1;
        left_data    = 16'hC3A5;
        right_data   = 16'h5A3C;
        pend         = '{l: 16'hC3A5, r: 16'h5A3C};
        hs_flag      = 1'b1;
        @(negedge in_clk);
        sample_valid = 1'b0;
        check("underrun_simul_load", underruns, u0 + 1);
        wait_frames(1);
        check("underrun_after_simul", underruns, u0 + 1);
        wait_frames(1);

        // Reset in the middle of a frame with a pair pending.
        offer(16'h9999, 16'h6666, 16'h9999, 16'h6666, 1'b0);
        k = 0;
        while (mp != 20 && k < 2000) begin
            @(negedge in_clk);
            k++;
        end
        check("reached_p20", mp, 20);
        check("pending_before_rst", sbq.size(), 1);
        rst_n   = 1'b0;
        sbq.delete();
        hs_flag = 1'b0;
        mp      = FL - 1;
        cur     = '0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge in_clk);
        rst_n = 1'b1;
        u0 = underruns;
        wait_frames(1);
        check("underrun_after_rst", underruns, u0 + 1);
        wait_frames(1);
        check("drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/i2s_tx.md
# i2s_tx

Serialises stereo PCM samples into a Philips-format I2S stream for the audio DAC. It sits directly downstream of the system clock divider and consumes the divided square wave as its bit clock (`bclk`). All logic runs on the system clock, with `bclk` treated as a synchronous level whose edges become one-cycle strobes. Samples come in through a one-deep valid/ready buffer; if no sample is waiting at a frame boundary, the block sends silence and flags an underrun.

## Interface
- `DATA_WIDTH`, 16: PCM bits per channel; must be less than `SLOT_WIDTH`.
- `SLOT_WIDTH`, 32: bit-clock periods per channel slot; a frame is 2*`SLOT_WIDTH` periods.
- `in_clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `bclk`  in  1  divided bit clock from the clock divider, synchronous to `in_clk`; each high and low phase lasts at least 2 `in_clk` cycles.
- `left_data`  in  `DATA_WIDTH`  left sample, two's complement.
- `right_data`  in  `DATA_WIDTH`  right sample, two's complement.
- `sample_valid`  in  1  left/right pair is offered.
- `sample_ready`  out  1  the buffer can accept a pair.
- `bclk_out`  out  1  bit clock to the DAC, aligned with `sdata`.
- `lrclk`  out  1  word select: 0 = left slot, 1 = right slot.
- `sdata`  out  1  serial data, MSB first.
- `underrun`  out  1  one-cycle pulse when a frame starts with no buffered sample.

## Operation
- Edge detection: `bclk_q` is `bclk` registered. A fall strobe is `bclk_q & ~bclk`.
- Position counter `p` runs 0..2*`SLOT_WIDTH`-1.
  - It advances on every fall strobe and wraps from 2*`SLOT_WIDTH`-1 to 0.
  - Reset value is 2*`SLOT_WIDTH`-1, so the first fall strobe after reset starts frame position 0.
- `lrclk` value driven for position `p`:
  - 0 for p < `SLOT_WIDTH`;
  - 1 otherwise.
- `sdata` value driven for position `p`:
  - left bit (`DATA_WIDTH`-p) for p = 1..`DATA_WIDTH`, so the MSB goes out at p = 1;
  - right bit (`DATA_WIDTH`-(p-`SLOT_WIDTH`)) for p = `SLOT_WIDTH`+1..`SLOT_WIDTH`+`DATA_WIDTH`;
  - 0 at every other position.
- Pending buffer: one left/right register pair plus a `full` flag.
  - `sample_ready` = ~`full`.
  - A handshake (`sample_valid` & `sample_ready`) captures both channels and sets `full`.
- Frame load happens on the fall strobe that moves `p` to 0.
  - If `full`: both shift registers load the pending pair and `full` clears.
  - If not `full`: both shift registers load zeros and `underrun` pulses high for exactly one cycle.
- Simultaneous handshake and frame load cannot occur with `full` = 1, because `sample_ready` is low.
  - With `full` = 0, the frame load sends zeros and flags underrun.
  - The handshake in that same cycle fills the buffer for the next frame.
- Reset, asynchronous and valid mid-frame, returns every register to its reset value and discards the buffered sample:
  - `sdata` = 0, `lrclk` = 1, `bclk_out` = 0, `sample_ready` = 1, `underrun` = 0;
  - `p` = 2*`SLOT_WIDTH`-1, `bclk_q` = 0, `full` = 0.

## Timing
- `p`, `lrclk` and `sdata` update on the `in_clk` edge that ends a fall-strobe cycle.
- `bclk_out` = `bclk_q`, so `bclk_out` falls on the same `in_clk` edge that `sdata`/`lrclk` change.
  - Data is therefore stable for the whole high phase of `bclk_out`, which the DAC samples on its rising edge.
- Latency from the `bclk` falling level to the output change is 1 `in_clk` cycle.
- `sample_ready` rises 1 cycle after the frame load that empties the buffer.
- The source has up to one full frame to refill the buffer before the next underrun.
- Rise strobes are not used.

## Structure
- A shared package `audio_pkg` holds the default `DATA_WIDTH` (16) and `SLOT_WIDTH` (32) constants and a frame-length function.
  - The codec-side blocks use the same package.
- One sub-module, `sync_edge_detect`: registers a synchronous level and outputs the delayed level plus rise and fall strobes.
  - It is reused by future audio receive blocks.
- The pending buffer, counter and shift registers stay inline in `i2s_tx`.

## Test plan
- Reset, then drive `bclk` as a divide-by-4 square wave with no samples.
  - Frame 1: `sdata` stays 0.
  - `underrun` pulses once per frame.
  - `lrclk` low for 32 `bclk_out` periods, then high for 32.
- Offer L=0x8001, R=0x7FFE before the first frame.
  - At p = 1..16, `sdata` shows 1000000000000001.
  - At p = 33..48, `sdata` shows 0111111111111110.
  - `underrun` stays 0.
- Hold `sample_valid` high continuously.
  - `sample_ready` drops after each accept and rises 1 cycle after each frame load.
  - Exactly one pair is consumed per frame.
- Assert `sample_valid` in the same cycle as a frame load with the buffer empty.
  - That frame sends zeros with an `underrun` pulse.
  - The next frame sends the new pair.
- Assert `rst_n` low at p = 20 with a sample pending.
  - All outputs return to their reset values immediately.
  - The first frame after release is silent with an underrun.
- Check bit alignment: every `sdata`/`lrclk` transition coincides with a `bclk_out` falling edge, and none occurs while `bclk_out` is high.
